ps2_mouse_packet_ctrl: RTL and testbench
========================================

// Module: ps2_mouse_packet_ctrl
// PURPOSE
//  Sequencer between the PS/2 byte receiver (ps2_keyboard-style FIFO with rdn pop) and objectMouseMove.
//  Assembles standard 3-byte PS/2 mouse packets, validates sync, and pops each byte from the receiver.
//  Resynchronises on inter-byte timeout and converts signed 9-bit deltas into magnitude+direction velocities.
//  Holds velocities for a fixed window, then clears them. Replaces the ad-hoc packet FSM in top.
// PARAMETERS
//  TIMEOUT_CYCLES  10_000_000  max clk cycles between bytes of one packet before resync
//  HOLD_CYCLES     10_000_000  clk cycles vx/vy stay valid after a packet, then forced to 0
//  VSHIFT          1           right-shift applied to delta magnitude (speed scaling)
// PORTS
//  clk          in   1   system clock (all logic on rising edge)
//  rst          in   1   synchronous, active-high reset
//  rx_ready     in   1   receiver FIFO non-empty (level, synchronous to clk)
//  rx_data      in   8   receiver FIFO head byte
//  rx_rdn       out  1   active-low pop strobe to receiver, one cycle per accepted byte
//  vx           out  10  |dx|>>VSHIFT, saturated; 0 outside hold window
//  vy           out  10  |dy|>>VSHIFT, saturated; 0 outside hold window
//  dx           out  1   1 = +X (right), 0 = -X
//  dy           out  1   1 = +Y per PS/2 sign (bit5 clear), 0 = negative
//  btn_left     out  1   left button level from last good packet
//  btn_right    out  1   right button level from last good packet
//  left_press   out  1   one-cycle pulse on left 0->1 between consecutive good packets
//  pkt_valid    out  1   one-cycle pulse when a good packet is decoded
//  sync_err     out  8   saturating count of discarded byte0s and timeouts
// BEHAVIOUR
//  Reset: state=WAIT_B0; rx_rdn=1; vx=vy=0; dx=dy=0; buttons=0; pulses=0; sync_err=0; timers=0.
//  Accept: byte accepted in cycle N when rx_ready=1 and no pop is outstanding (rx_rdn=1 and accepted-last-cycle=0).
//   rx_rdn=0 in cycle N+1 only. A ready level that persists after a pop is not re-accepted until one cycle after the pop.
//  FSM:
//   WAIT_B0: accepted byte with bit3=1 -> latch as b0, go WAIT_B1. With bit3=0 -> discard, sync_err++, stay.
//   WAIT_B1: accept -> latch b1, go WAIT_B2; inter-byte timer==TIMEOUT_CYCLES-1 -> WAIT_B0, sync_err++.
//   WAIT_B2: accept -> latch b2, go WAIT_B0, decode; timeout as in WAIT_B1.
//  Timer: cleared on every accept; counts only in WAIT_B1/WAIT_B2. Accept and timeout in the same cycle:
//   accept wins and the timer restarts.
//  Decode (registered, outputs update in cycle N+1 after byte2 accept, with pkt_valid=1 in that cycle):
//   sx=b0[4], sy=b0[5]; DX9={sx,b1}, DY9={sy,b2}; mag = sign ? (~v[7:0]+1) : v[7:0] (9-bit, so -256 -> 256).
//   Overflow b0[6]/b0[7] forces that axis mag to 255. v = min(mag>>VSHIFT, 1023), zero-extended to 10 bits.
//   dx=~sx, dy=~sy; btn_left=b0[0], btn_right=b0[1]; left_press=b0[0]&~prev_left; prev_left updated.
//  Hold: hold counter loads HOLD_CYCLES-1 on pkt_valid and decrements. vx/vy are forced to 0 when it reaches 0.
//   dx/dy/buttons hold their value. A new packet during the hold reloads the counter.
//  sync_err saturates at 255 and never wraps.
//  rst asserted mid-packet: partial packet dropped, all outputs return to reset values on the next cycle.
//   A pop already strobed is not repeated.
// STRUCTURE
//  Shared package ps2_mouse_pkg: state encodings (WAIT_B0/B1/B2), b0 bit positions
//   (LEFT=0, RIGHT=1, SYNC=3, SX=4, SY=5, OVX=6, OVY=7), overflow magnitude constant 255.
//  One sub-module: ps2_axis_conv (9-bit signed + overflow -> 10-bit saturated magnitude + dir). Instantiated twice.
//  FSM, timers, pop logic and output registers stay in this module.
// TESTING
//  1 Bytes 0x09,0x05,0x00 -> pkt_valid once; vx=2, dx=1, vy=0, btn_left=1, left_press=1; exactly 3 rx_rdn pulses.
//  2 Bytes 0x38,0xFB,0xF6 -> vx=2, dx=0, vy=5, dy=0, btn_left=0; next packet 0x09 -> left_press=1.
//  3 Byte 0x05 (bit3=0), then 0x08,0x02,0x02 -> sync_err=1, one pkt_valid with vx=1, vy=1.
//  4 0x08,0x04, then silence for TIMEOUT_CYCLES -> WAIT_B0, sync_err=1, no pkt_valid. Following 0x08,0x02,0x02 decodes normally.
//  5 0x48,0x10,0x00 (X overflow) -> vx=127; 0x18,0x00,0x00 (X=-256) -> vx=128, dx=0. After HOLD_CYCLES idle -> vx=vy=0.
//  6 rst pulsed between byte1 and byte2, then 0x08,0x02,0x02 -> outputs zero during rst, one correct packet after.

Source files
------------

// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet path: sequencer states, byte0 field
// positions and a saturating increment for the sync error counter.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } pkt_state_t;

    localparam int B0_LEFT  = 0;
    localparam int B0_RIGHT = 1;
    localparam int B0_SYNC  = 3;
    localparam int B0_SX    = 4;
    localparam int B0_SY    = 5;
    localparam int B0_OVX   = 6;
    localparam int B0_OVY   = 7;

    localparam logic [8:0] OVF_MAG = 9'd255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ps2_axis_conv.sv
// One mouse axis: 9-bit sign+byte delta with overflow flag to scaled 10-bit
// magnitude and a direction bit (1 = positive).
module ps2_axis_conv
    import ps2_mouse_pkg::*;
#(
    parameter int VSHIFT = 1
) (
    input  logic       sign,
    input  logic [7:0] val,
    input  logic       ovf,
    output logic [9:0] vel,
    output logic       dir
);

    logic [8:0] mag;

    always_comb begin
        mag = {1'b0, val};
        if (ovf)
            mag = OVF_MAG;
        else if (sign)
            mag = {1'b0, ~val} + 9'd1;   // 9 bits so that -256 yields 256
    end

    // A 9-bit magnitude never exceeds 1023, so widening is the saturation.
    assign vel = {1'b0, mag} >> VSHIFT;
    assign dir = ~sign;

endmodule

// File: rtl/ps2_mouse_packet_ctrl.sv
// Assembles 3-byte PS/2 mouse packets from the receiver FIFO, pops each byte,
// resyncs on timeout and drives held velocities and button state.
//
//  state   | meaning
//  WAIT_B0 | hunting for a byte0 with the sync bit set
//  WAIT_B1 | byte0 latched, waiting for the X delta byte
//  WAIT_B2 | byte1 latched, waiting for the Y delta byte, then decode
module ps2_mouse_packet_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10_000_000,
    parameter int HOLD_CYCLES    = 10_000_000,
    parameter int VSHIFT         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       rx_rdn,
    output logic [9:0] vx,
    output logic [9:0] vy,
    output logic       dx,
    output logic       dy,
    output logic       btn_left,
    output logic       btn_right,
    output logic       left_press,
    output logic       pkt_valid,
    output logic [7:0] sync_err
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    pkt_state_t    state;
    logic [7:0]    b0_q;
    logic [7:0]    b1_q;
    logic [TW-1:0] tmr;
    logic [HW-1:0] hold_cnt;

    logic       accept;
    logic       timeout;
    logic [9:0] vel_x, vel_y;
    logic       dir_x, dir_y;

    // rx_rdn is low exactly in the cycle after an accept, which blocks re-accept.
    assign accept  = rx_ready & rx_rdn;
    assign timeout = (state != WAIT_B0) && (tmr == TO_LAST);

    // Y byte is taken straight from the FIFO head so decode lands one cycle after accept.
    ps2_axis_conv #(.VSHIFT(VSHIFT)) u_conv_x (
        .sign (b0_q[B0_SX]),
        .val  (b1_q),
        .ovf  (b0_q[B0_OVX]),
        .vel  (vel_x),
        .dir  (dir_x)
    );

    ps2_axis_conv #(.VSHIFT(VSHIFT)) u_conv_y (
        .sign (b0_q[B0_SY]),
        .val  (rx_data),
        .ovf  (b0_q[B0_OVY]),
        .vel  (vel_y),
        .dir  (dir_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_B0;
            b0_q       <= 8'd0;
            b1_q       <= 8'd0;
            tmr        <= '0;
            hold_cnt   <= '0;
            rx_rdn     <= 1'b1;
            vx         <= 10'd0;
            vy         <= 10'd0;
            dx         <= 1'b0;
            dy         <= 1'b0;
            btn_left   <= 1'b0;
            btn_right  <= 1'b0;
            left_press <= 1'b0;
            pkt_valid  <= 1'b0;
            sync_err   <= 8'd0;
        end else begin
            rx_rdn     <= ~accept;
            pkt_valid  <= 1'b0;
            left_press <= 1'b0;

            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
                if (hold_cnt == HW'(1)) begin
                    vx <= 10'd0;
                    vy <= 10'd0;
                end
            end

            case (state)
                WAIT_B0: begin
                    tmr <= '0;
                    if (accept) begin
                        if (rx_data[B0_SYNC]) begin
                            b0_q  <= rx_data;
                            state <= WAIT_B1;
                        end else begin
                            sync_err <= sat_inc8(sync_err);
                        end
                    end
                end
                WAIT_B1: begin
                    if (accept) begin
                        b1_q  <= rx_data;
                        tmr   <= '0;
                        state <= WAIT_B2;
                    end else if (timeout) begin
                        tmr      <= '0;
                        state    <= WAIT_B0;
                        sync_err <= sat_inc8(sync_err);
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                WAIT_B2: begin
                    if (accept) begin
                        tmr        <= '0;
                        state      <= WAIT_B0;
                        vx         <= vel_x;
                        vy         <= vel_y;
                        dx         <= dir_x;
                        dy         <= dir_y;
                        btn_left   <= b0_q[B0_LEFT];
                        btn_right  <= b0_q[B0_RIGHT];
                        left_press <= b0_q[B0_LEFT] & ~btn_left;
                        pkt_valid  <= 1'b1;
                        hold_cnt   <= HOLD_LOAD;
                    end else if (timeout) begin
                        tmr      <= '0;
                        state    <= WAIT_B0;
                        sync_err <= sat_inc8(sync_err);
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                default: begin
                    tmr   <= '0;
                    state <= WAIT_B0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet_ctrl.sv
// Bench for ps2_mouse_packet_ctrl: table of packets checked through a scoreboard
// queue, plus hand sequences for resync, timeout, hold window, reset and saturation.
module tb_ps2_mouse_packet_ctrl;

    localparam int TO   = 40;
    localparam int HOLD = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_rdn;
    logic [9:0] vx, vy;
    logic       dx, dy, btn_left, btn_right, left_press, pkt_valid;
    logic [7:0] sync_err;

    ps2_mouse_packet_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .HOLD_CYCLES    (HOLD),
        .VSHIFT         (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_rdn     (rx_rdn),
        .vx         (vx),
        .vy         (vy),
        .dx         (dx),
        .dy         (dy),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .left_press (left_press),
        .pkt_valid  (pkt_valid),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         vx, vy, dx, dy, bl, br, lp;
    } pkt_t;

    pkt_t tbl[10];
    pkt_t exp_q[$];
    int   total = 0, bad = 0;
    int   pops = 0, pkts = 0, bytes_sent = 0, pushes = 0;

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic monitor();
        pkt_t e;
        forever begin
            @(negedge clk);
            if (!rst && !rx_rdn) pops++;
            if (pkt_valid) begin
                pkts++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pkt_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("vx[%h %h %h]", e.b0, e.b1, e.b2), int'(vx), e.vx);
                    chk($sformatf("vy[%h %h %h]", e.b0, e.b1, e.b2), int'(vy), e.vy);
                    chk($sformatf("dx[%h %h %h]", e.b0, e.b1, e.b2), int'(dx), e.dx);
                    chk($sformatf("dy[%h %h %h]", e.b0, e.b1, e.b2), int'(dy), e.dy);
                    chk($sformatf("btn_left[%h]", e.b0), int'(btn_left), e.bl);
                    chk($sformatf("btn_right[%h]", e.b0), int'(btn_right), e.br);
                    chk($sformatf("left_press[%h]", e.b0), int'(left_press), e.lp);
                end
            end
        end
    endtask

    // Called on a negedge; returns on a negedge with ready dropped and the pop finished.
    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        rx_ready = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!rx_rdn) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("pop_wait_expired", 0, 1);
        rx_ready = 1'b0;
        bytes_sent++;
        @(negedge clk);
    endtask

    task automatic send_pkt(input pkt_t p);
        exp_q.push_back(p);
        pushes++;
        send_byte(p.b0);
        send_byte(p.b1);
        send_byte(p.b2);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic burst(input int n);
        rx_ready = 1'b1;
        rx_data  = 8'h00;
        repeat (n) @(negedge clk);
        rx_ready = 1'b0;
        bytes_sent += n / 2;
        @(negedge clk);
    endtask

    pkt_t p;

    initial begin
        //           b0     b1     b2     vx   vy  dx dy bl br lp
        tbl[0] = '{8'h09, 8'h05, 8'h00,   2,   0, 1, 1, 1, 0, 1};
        tbl[1] = '{8'h38, 8'hFB, 8'hF6,   2,   5, 0, 0, 0, 0, 0};
        tbl[2] = '{8'h09, 8'h00, 8'h00,   0,   0, 1, 1, 1, 0, 1};
        tbl[3] = '{8'h0B, 8'h00, 8'h00,   0,   0, 1, 1, 1, 1, 0};
        tbl[4] = '{8'h48, 8'h10, 8'h00, 127,   0, 1, 1, 0, 0, 0};
        tbl[5] = '{8'h18, 8'h00, 8'h00, 128,   0, 0, 1, 0, 0, 0};
        tbl[6] = '{8'h28, 8'h00, 8'h80,   0,  64, 1, 0, 0, 0, 0};
        tbl[7] = '{8'h88, 8'h02, 8'h02,   1, 127, 1, 1, 0, 0, 0};
        tbl[8] = '{8'h08, 8'h7F, 8'hFE,  63, 127, 1, 1, 0, 0, 0};
        tbl[9] = '{8'h09, 8'hFF, 8'h01, 127,   0, 1, 1, 1, 0, 1};

        rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00;
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        chk("reset_rx_rdn", int'(rx_rdn), 1);
        chk("reset_vx_vy", int'({vx, vy}), 0);
        chk("reset_dirs_btns", int'({dx, dy, btn_left, btn_right, left_press, pkt_valid}), 0);
        chk("reset_sync_err", int'(sync_err), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            send_pkt(tbl[i]);
            drain($sformatf("table_pkt%0d_seen", i));
        end
        chk("table_pops", pops, 30);
        chk("table_pkts", pkts, 10);

        // bad byte0 discarded, then a clean packet
        send_byte(8'h05);
        chk("sync_err_after_bad_b0", int'(sync_err), 1);
        p = '{8'h08, 8'h02, 8'h02, 1, 1, 1, 1, 0, 0, 0};
        send_pkt(p);
        drain("resync_pkt_seen");
        chk("sync_err_stable", int'(sync_err), 1);

        // ready held high: every other cycle is an accept
        burst(8);
        chk("burst_sync_err", int'(sync_err), 5);
        chk("burst_pops", pops, bytes_sent);

        // inter-byte timeout
        send_byte(8'h08);
        send_byte(8'h04);
        repeat (TO + 5) @(negedge clk);
        chk("timeout_sync_err", int'(sync_err), 6);
        chk("timeout_no_pkt", pkts, pushes);
        send_pkt(p);
        drain("post_timeout_pkt_seen");
        chk("post_timeout_sync_err", int'(sync_err), 6);

        // gap just inside the timeout
        exp_q.push_back(p);
        pushes++;
        send_byte(8'h08);
        repeat (TO - 10) @(negedge clk);
        send_byte(8'h02);
        send_byte(8'h02);
        drain("long_gap_pkt_seen");
        chk("long_gap_sync_err", int'(sync_err), 6);

        // hold window expiry
        p = '{8'h08, 8'h0A, 8'h00, 5, 0, 1, 1, 0, 0, 0};
        send_pkt(p);
        drain("hold_pkt_seen");
        repeat (100) @(negedge clk);
        chk("hold_vx_inside", int'(vx), 5);
        repeat (250) @(negedge clk);
        chk("hold_vx_expired", int'(vx), 0);
        chk("hold_dx_kept", int'(dx), 1);

        // new packet reloads the hold counter
        p = '{8'h08, 8'h14, 8'h00, 10, 0, 1, 1, 0, 0, 0};
        send_pkt(p);
        drain("reload_pkt1_seen");
        repeat (200) @(negedge clk);
        p = '{8'h08, 8'h0A, 8'h00, 5, 0, 1, 1, 0, 0, 0};
        send_pkt(p);
        drain("reload_pkt2_seen");
        repeat (200) @(negedge clk);
        chk("reload_vx_held", int'(vx), 5);
        repeat (150) @(negedge clk);
        chk("reload_vx_expired", int'(vx), 0);

        // reset mid-packet
        p = '{8'h09, 8'h0A, 8'h00, 5, 0, 1, 1, 1, 0, 1};
        send_pkt(p);
        drain("pre_reset_pkt_seen");
        send_byte(8'h08);
        send_byte(8'h02);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_vx", int'(vx), 0);
        chk("rst_btn_dirs", int'({dx, dy, btn_left, btn_right}), 0);
        chk("rst_sync_err", int'(sync_err), 0);
        chk("rst_rx_rdn", int'(rx_rdn), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        p = '{8'h09, 8'h02, 8'h02, 1, 1, 1, 1, 1, 0, 1};
        send_pkt(p);
        drain("post_reset_pkt_seen");
        chk("post_reset_sync_err", int'(sync_err), 0);

        // sync_err saturation: 300 discarded byte0s
        burst(600);
        chk("sync_err_saturated", int'(sync_err), 255);
        chk("final_pops", pops, bytes_sent);
        chk("final_pkts", pkts, pushes);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
